// File: rtl/sram_ctrl_pkg.sv
//============================================================================
// Module      : sram_ctrl_pkg
// Description : Shared FSM state type and constant helpers for sram_ctrl_param.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int WAIT_CNT_W = 4;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // BEATS: SRAM beats per CPU word; BYTE_SHIFT: byte-to-word address shift.
   function automatic int beats_of(input int data_w, input int sram_dw);
      return data_w / sram_dw;
   endfunction

   function automatic int byte_shift_of(input int data_w);
      return clog2(data_w / 8);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_dq_pad.sv
//============================================================================
// Module      : sram_dq_pad
// Description : Tri-state driver for the bidirectional SRAM data bus.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module sram_dq_pad #(
   parameter int WIDTH = 16
) (
   input  logic             i_oe,
   input  logic [WIDTH-1:0] i_dout,
   output logic [WIDTH-1:0] o_din,
   inout  wire  [WIDTH-1:0] io_dq
);

   assign io_dq = i_oe ? i_dout : {WIDTH{1'bz}};
   assign o_din = io_dq;

endmodule

`default_nettype wire

// File: rtl/sram_ctrl_param.sv
//============================================================================
// Module      : sram_ctrl_param
// Description : Splits a DATA_W CPU access into SRAM_DW beats with wait states.
//               Optional address checking via macro SRAM_CTRL_ADDR_CHECK_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module sram_ctrl_param
   import sram_ctrl_pkg::*;
#(
   parameter int          DATA_W      = 32,
   parameter int          SRAM_DW     = 16,
   parameter int          SRAM_AW     = 18,
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [DATA_W-1:0]  write_data,
   output logic [DATA_W-1:0]  read_data,
   output logic               ready,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   output logic               SRAM_OE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N
`ifdef SRAM_CTRL_ADDR_CHECK_EN
   ,
   output logic               addr_err
`endif
);

   localparam int BEATS        = beats_of(DATA_W, SRAM_DW);
   localparam int BYTE_SHIFT   = byte_shift_of(DATA_W);
   localparam int c_beat_shift = clog2(BEATS);
   localparam int c_beat_w     = (BEATS > 1) ? c_beat_shift : 1;

   localparam logic [c_beat_w-1:0]   c_last_beat = c_beat_w'(BEATS - 1);
   localparam logic [WAIT_CNT_W-1:0] c_last_wait =
      WAIT_CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   state_t               r_state;
   logic [c_beat_w-1:0]  r_beat;
   logic [WAIT_CNT_W-1:0] r_wait;
   logic                 r_is_wr;
   logic [DATA_W-1:0]    r_wshift;
   logic [SRAM_AW-1:0]   r_addr;
   logic                 r_we_n;
   logic                 r_oe_n;
   logic                 r_dq_oe;
   logic [SRAM_DW-1:0]   r_dout;
   logic [DATA_W-1:0]    r_rdata;

   logic                 w_req;
   logic [31:0]          w_off;
   logic [31:0]          w_word;
   logic [SRAM_AW-1:0]   w_base;
   logic [SRAM_DW-1:0]   w_din;
   logic                 w_bad;

   assign w_req  = wr_en | rd_en;
   assign w_off  = address - BASE_ADDR;
   assign w_word = w_off >> BYTE_SHIFT;
   // BEATS is a power of two, so word*BEATS is a shift; truncation wraps the SRAM.
   assign w_base = SRAM_AW'(w_word << c_beat_shift);

`ifdef SRAM_CTRL_ADDR_CHECK_EN
   localparam logic [31:0] c_align_mask = 32'((64'd1 << BYTE_SHIFT) - 64'd1);
   logic [63:0] w_last;
   logic        r_addr_err;

   assign w_last = ({32'd0, w_word} << c_beat_shift) + 64'(BEATS - 1);
   assign w_bad  = (address < BASE_ADDR) ||
                   ((address & c_align_mask) != 32'd0) ||
                   (w_last >= (64'd1 << SRAM_AW));
   assign addr_err = r_addr_err;
`else
   assign w_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_beat   <= '0;
         r_wait   <= '0;
         r_is_wr  <= 1'b0;
         r_wshift <= '0;
         r_addr   <= '0;
         r_we_n   <= 1'b1;
         r_oe_n   <= 1'b1;
         r_dq_oe  <= 1'b0;
         r_dout   <= '0;
         r_rdata  <= '0;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
         r_addr_err <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_is_wr <= wr_en;
                  r_beat  <= '0;
                  if (w_bad) begin
                     r_state <= DONE;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
                     r_addr_err <= 1'b1;
`endif
                  end else begin
                     // Beat 0 strobes are registered here so they appear in cycle 1.
                     r_state  <= ACCESS;
                     r_addr   <= w_base;
                     r_we_n   <= ~wr_en;
                     r_oe_n   <= wr_en;
                     r_dq_oe  <= wr_en;
                     r_dout   <= write_data[SRAM_DW-1:0];
                     r_wshift <= write_data >> SRAM_DW;
                  end
               end
            end
            ACCESS: begin
               if (!r_is_wr) begin
                  r_rdata[r_beat*SRAM_DW +: SRAM_DW] <= w_din;
               end
               if (r_beat == c_last_beat) begin
                  r_we_n  <= 1'b1;
                  r_oe_n  <= 1'b1;
                  r_dq_oe <= 1'b0;
                  r_wait  <= '0;
                  r_state <= (WAIT_CYCLES == 0) ? DONE : WAIT;
               end else begin
                  r_beat   <= r_beat + 1'b1;
                  r_addr   <= r_addr + 1'b1;
                  r_dout   <= r_wshift[SRAM_DW-1:0];
                  r_wshift <= r_wshift >> SRAM_DW;
               end
            end
            WAIT: begin
               if (r_wait == c_last_wait) begin
                  r_state <= DONE;
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
               r_addr_err <= 1'b0;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   sram_dq_pad #(
      .WIDTH (SRAM_DW)
   ) u_dq_pad (
      .i_oe   (r_dq_oe),
      .i_dout (r_dout),
      .o_din  (w_din),
      .io_dq  (SRAM_DQ)
   );

   assign ready     = (r_state == DONE) | ~w_req;
   assign read_data = r_rdata;
   assign SRAM_ADDR = r_addr;
   assign SRAM_WE_N = r_we_n;
   assign SRAM_OE_N = r_oe_n;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_sram_ctrl_param.sv
//============================================================================
// Module      : tb_sram_ctrl_param
// Description : Scoreboard bench for sram_ctrl_param (default and 64-bit builds).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_sram_ctrl_param;

   typedef struct {
      int unsigned addr;
      bit          wr;
      logic [15:0] data;
   } beat_t;

   typedef struct {
      int          cyc;
      logic [63:0] rdata;
      bit          err;
   } done_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // default instance: DATA_W=32, WAIT_CYCLES=2
   logic        a_wr = 0, a_rd = 0;
   logic [31:0] a_addr = 0, a_wdata = 0, a_rdata;
   logic        a_ready, a_we, a_oe, a_ce, a_ub, a_lb;
   logic [17:0] a_sa;
   wire  [15:0] a_dq;
   // 64-bit instance with no wait states
   logic        b_wr = 0, b_rd = 0;
   logic [31:0] b_addr = 0;
   logic [63:0] b_wdata = 0, b_rdata;
   logic        b_ready, b_we, b_oe, b_ce, b_ub, b_lb;
   logic [17:0] b_sa;
   wire  [15:0] b_dq;
`ifdef SRAM_CTRL_ADDR_CHECK_EN
   logic        a_err, b_err;
`endif

   sram_ctrl_param u_dut_a (
      .clk(clk), .rst(rst_n), .wr_en(a_wr), .rd_en(a_rd), .address(a_addr),
      .write_data(a_wdata), .read_data(a_rdata), .ready(a_ready), .SRAM_DQ(a_dq),
      .SRAM_ADDR(a_sa), .SRAM_WE_N(a_we), .SRAM_OE_N(a_oe), .SRAM_CE_N(a_ce),
      .SRAM_UB_N(a_ub), .SRAM_LB_N(a_lb)
`ifdef SRAM_CTRL_ADDR_CHECK_EN
      , .addr_err(a_err)
`endif
   );

   sram_ctrl_param #(.DATA_W(64), .WAIT_CYCLES(0)) u_dut_b (
      .clk(clk), .rst(rst_n), .wr_en(b_wr), .rd_en(b_rd), .address(b_addr),
      .write_data(b_wdata), .read_data(b_rdata), .ready(b_ready), .SRAM_DQ(b_dq),
      .SRAM_ADDR(b_sa), .SRAM_WE_N(b_we), .SRAM_OE_N(b_oe), .SRAM_CE_N(b_ce),
      .SRAM_UB_N(b_ub), .SRAM_LB_N(b_lb)
`ifdef SRAM_CTRL_ADDR_CHECK_EN
      , .addr_err(b_err)
`endif
   );

   // SRAM models
   logic [15:0] mem_a [0:262143];
   logic [15:0] mem_b [0:262143];
   logic        pl_en = 0;
   logic [17:0] pl_addr = 0;
   logic [15:0] pl_data = 0;

   assign a_dq = (!a_oe && a_we) ? mem_a[a_sa] : 16'bz;
   assign b_dq = (!b_oe && b_we) ? mem_b[b_sa] : 16'bz;

   always @(posedge clk) begin
      if (pl_en)              mem_a[pl_addr] <= pl_data;
      else if (rst_n && !a_we) mem_a[a_sa]   <= a_dq;
   end
   always @(posedge clk) if (rst_n && !b_we) mem_b[b_sa] <= b_dq;

   beat_t qa_beat[$], qb_beat[$];
   done_t qa_done[$], qb_done[$];
   beat_t eb_a, eb_b;
   done_t ed_a, ed_b;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_beat(input string nm, input logic [17:0] sa, input logic we,
                           input logic oe, input logic [15:0] dq, input beat_t e);
      chk({nm, "_addr"}, 64'(sa), 64'(e.addr));
      chk({nm, "_strobe"}, {62'd0, we, oe}, e.wr ? 64'd1 : 64'd2);
      if (e.wr) chk({nm, "_dq"}, 64'(dq), 64'(e.data));
   endtask

   // Monitors: compare every SRAM strobe and every completion against the queues.
   always @(negedge clk) begin
      if (rst_n) begin
         if (!a_we || !a_oe) begin
            if (qa_beat.size() == 0) chk("a_unexpected_beat", 64'(a_sa), 64'hFFFF_FFFF);
            else begin
               eb_a = qa_beat.pop_front();
               chk_beat("a_beat", a_sa, a_we, a_oe, a_dq, eb_a);
            end
         end
         if (a_ready && (a_wr || a_rd)) begin
            if (qa_done.size() == 0) chk("a_unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
            else begin
               ed_a = qa_done.pop_front();
               chk("a_done_cyc", 64'(cyc), 64'(ed_a.cyc));
               chk("a_rdata", 64'(a_rdata), ed_a.rdata);
`ifdef SRAM_CTRL_ADDR_CHECK_EN
               chk("a_addr_err", 64'(a_err), 64'(ed_a.err));
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (!b_we || !b_oe) begin
            if (qb_beat.size() == 0) chk("b_unexpected_beat", 64'(b_sa), 64'hFFFF_FFFF);
            else begin
               eb_b = qb_beat.pop_front();
               chk_beat("b_beat", b_sa, b_we, b_oe, b_dq, eb_b);
            end
         end
         if (b_ready && (b_wr || b_rd)) begin
            if (qb_done.size() == 0) chk("b_unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
            else begin
               ed_b = qb_done.pop_front();
               chk("b_done_cyc", 64'(cyc), 64'(ed_b.cyc));
               chk("b_rdata", b_rdata, ed_b.rdata);
            end
         end
      end
   end

   function automatic beat_t mkb(input int unsigned a, input bit w, input logic [15:0] d);
      beat_t b;
      b.addr = a;
      b.wr   = w;
      b.data = d;
      return b;
   endfunction

   task automatic preload(input logic [17:0] adr, input logic [15:0] d);
      @(posedge clk); #1;
      pl_en = 1; pl_addr = adr; pl_data = d;
      @(posedge clk); #1;
      pl_en = 0;
   endtask

   // Hold a request for 'reps' completions; each completion lands 'lat' cycles after its start.
   task automatic go(input bit sel_b, input bit wr, input bit rd, input logic [31:0] adr,
                     input logic [63:0] wd, input int reps, input int lat,
                     input logic [63:0] exp_rd, input bit err);
      done_t d;
      int    seen;
      int    budget;
      @(posedge clk); #1;
      for (int r = 0; r < reps; r++) begin
         d.cyc = cyc + r * (lat + 1) + lat;
         d.rdata = exp_rd;
         d.err = err;
         if (sel_b) qb_done.push_back(d); else qa_done.push_back(d);
      end
      if (sel_b) begin b_wr = wr; b_rd = rd; b_addr = adr; b_wdata = wd; end
      else begin a_wr = wr; a_rd = rd; a_addr = adr; a_wdata = wd[31:0]; end
      seen = 0;
      budget = 0;
      while (seen < reps && budget < 100) begin
         @(negedge clk);
         budget++;
         if (sel_b ? b_ready : a_ready) seen++;
      end
      if (seen < reps) chk("ready_timeout", 64'(seen), 64'(reps));
      @(posedge clk); #1;
      a_wr = 0; a_rd = 0; b_wr = 0; b_rd = 0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready_idle", 64'(a_ready), 64'd1);
      chk("rst_we_n", 64'(a_we), 64'd1);
      chk("rst_oe_n", 64'(a_oe), 64'd1);
      chk("rst_sram_addr", 64'(a_sa), 64'd0);
      chk("rst_rdata", 64'(a_rdata), 64'd0);
      chk("rst_ties", {61'd0, a_ce, a_ub, a_lb}, 64'd0);
      a_rd = 1; #1;
      chk("rst_ready_req", 64'(a_ready), 64'd0);
      a_rd = 0;
      @(posedge clk); #1;
      rst_n = 1;
      repeat (2) @(posedge clk);

      // write 0xDEADBEEF to 1032 -> SRAM words 4,5
      qa_beat.push_back(mkb(4, 1, 16'hBEEF));
      qa_beat.push_back(mkb(5, 1, 16'hDEAD));
      go(0, 1, 0, 32'd1032, 64'hDEADBEEF, 1, 5, 64'd0, 0);

      // read 1032 from preloaded words; write_data kept all-ones to expose bus contention
      preload(4, 16'hBEEF);
      preload(5, 16'hDEAD);
      qa_beat.push_back(mkb(4, 0, 16'h0));
      qa_beat.push_back(mkb(5, 0, 16'h0));
      go(0, 0, 1, 32'd1032, 64'hFFFFFFFF, 1, 5, 64'hDEADBEEF, 0);

      preload(0, 16'h3344);
      preload(1, 16'h1122);
      qa_beat.push_back(mkb(0, 0, 16'h0));
      qa_beat.push_back(mkb(1, 0, 16'h0));
      go(0, 0, 1, 32'd1024, 64'hFFFFFFFF, 1, 5, 64'h11223344, 0);

      // write held across DONE executes twice; read_data untouched by writes
      for (int r = 0; r < 2; r++) begin
         qa_beat.push_back(mkb(8, 1, 16'hF00D));
         qa_beat.push_back(mkb(9, 1, 16'hCAFE));
      end
      go(0, 1, 0, 32'd1040, 64'hCAFEF00D, 2, 5, 64'h11223344, 0);

`ifndef SRAM_CTRL_ADDR_CHECK_EN
      // 1024 + 4*2^17 wraps to SRAM words 0,1
      qa_beat.push_back(mkb(0, 1, 16'h33CC));
      qa_beat.push_back(mkb(1, 1, 16'h55AA));
      go(0, 1, 0, 32'd525312, 64'h55AA33CC, 1, 5, 64'h11223344, 0);
      qa_beat.push_back(mkb(0, 0, 16'h0));
      qa_beat.push_back(mkb(1, 0, 16'h0));
      go(0, 0, 1, 32'd1024, 64'hFFFFFFFF, 1, 5, 64'h55AA33CC, 0);
`else
      // invalid addresses finish in cycle 1 with addr_err and no strobes
      go(0, 0, 1, 32'd1000, 64'hFFFFFFFF, 1, 1, 64'h11223344, 1);
      go(0, 0, 1, 32'd1026, 64'hFFFFFFFF, 1, 1, 64'h11223344, 1);
      preload(2, 16'h4321);
      preload(3, 16'h8765);
      qa_beat.push_back(mkb(2, 0, 16'h0));
      qa_beat.push_back(mkb(3, 0, 16'h0));
      go(0, 0, 1, 32'd1028, 64'hFFFFFFFF, 1, 5, 64'h87654321, 0);
`endif

      // wr_en and rd_en together at 1036 -> write; reset aborts it during beat 1
      qa_beat.push_back(mkb(6, 1, 16'hC0DE));
      @(posedge clk); #1;
      a_wr = 1; a_rd = 1; a_addr = 32'd1036; a_wdata = 32'h0BADC0DE;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      chk("abort_we_n", 64'(a_we), 64'd1);
      chk("abort_oe_n", 64'(a_oe), 64'd1);
      chk("abort_sram_addr", 64'(a_sa), 64'd0);
      chk("abort_rdata", 64'(a_rdata), 64'd0);
      chk("abort_ready_req", 64'(a_ready), 64'd0);
      a_wr = 0; a_rd = 0; #1;
      chk("abort_ready_idle", 64'(a_ready), 64'd1);
      @(posedge clk); #1;
      rst_n = 1;
      repeat (3) @(posedge clk);
      preload(6, 16'h7788);
      preload(7, 16'h5566);
      qa_beat.push_back(mkb(6, 0, 16'h0));
      qa_beat.push_back(mkb(7, 0, 16'h0));
      go(0, 0, 1, 32'd1036, 64'hFFFFFFFF, 1, 5, 64'h55667788, 0);

      // 64-bit build: four beats, no wait states
      qb_beat.push_back(mkb(0, 1, 16'hCDEF));
      qb_beat.push_back(mkb(1, 1, 16'h89AB));
      qb_beat.push_back(mkb(2, 1, 16'h4567));
      qb_beat.push_back(mkb(3, 1, 16'h0123));
      go(1, 1, 0, 32'd1024, 64'h0123456789ABCDEF, 1, 5, 64'd0, 0);
      for (int k = 0; k < 4; k++) qb_beat.push_back(mkb(k, 0, 16'h0));
      go(1, 0, 1, 32'd1024, 64'hFFFFFFFFFFFFFFFF, 1, 5, 64'h0123456789ABCDEF, 0);

      repeat (4) @(posedge clk);
      chk("a_beats_left", 64'(qa_beat.size()), 64'd0);
      chk("a_done_left", 64'(qa_done.size()), 64'd0);
      chk("b_beats_left", 64'(qb_beat.size()), 64'd0);
      chk("b_done_left", 64'(qb_done.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sram_ctrl_param.md
Name: sram_ctrl_param

Overview:
- Parametrised successor to the MEM-stage SRAM controller.
- Splits one DATA_W-bit CPU access into N = DATA_W/SRAM_DW sequential SRAM beats, with configurable wait states and base-address offset.
- Drives a registered, properly tri-stated SRAM bus and returns a registered read word.
- Stalls the pipeline via `ready` until the access completes.

Parameters:
- DATA_W, 32: CPU data width; integer multiple of SRAM_DW, power of two.
- SRAM_DW, 16: SRAM data-bus width.
- SRAM_AW, 18: SRAM address width.
- BASE_ADDR, 1024: CPU byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: idle cycles after the last beat before DONE; 0..15 allowed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- wr_en  in  1  write request; held until ready.
- rd_en  in  1  read request; held until ready.
- address  in  32  CPU byte address.
- write_data  in  DATA_W  write word.
- read_data  out  DATA_W  registered read word.
- ready  out  1  high = no stall.
- SRAM_DQ  inout  SRAM_DW  SRAM data bus.
- SRAM_ADDR  out  SRAM_AW  SRAM word address, registered.
- SRAM_WE_N  out  1  write strobe, registered.
- SRAM_OE_N  out  1  output enable, registered.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  tied 0.

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE; beat and wait counters 0.
- SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, SRAM_DQ=Z, read_data=0.
- ready = ~(wr_en|rd_en), combinational.
- Reset mid-access aborts immediately with no further SRAM strobes; the request restarts after rst=1.

Address mapping:
- off = address − BASE_ADDR, modulo 2^32.
- word = off >> log2(DATA_W/8).
- beat k goes to SRAM_ADDR = word*N + k, truncated to SRAM_AW, so addresses wrap modulo SRAM size.
- Beat 0 carries bits [SRAM_DW-1:0]; beats go LSB first.

Request capture:
- In IDLE, wr_en|rd_en latches op, address and write_data.
- wr_en has priority when both are high; this is a write.
- Later input changes are ignored until DONE.

FSM:
- IDLE → ACCESS on a request.
- ACCESS lasts N cycles; beat counter 0..N-1.
- ACCESS → WAIT after beat N-1, or → DONE directly if WAIT_CYCLES=0.
- WAIT lasts WAIT_CYCLES cycles.
- DONE lasts 1 cycle with ready=1, then → IDLE.

Write beat:
- SRAM_WE_N=0.
- SRAM_DQ driven with beat data for the full beat cycle.
- SRAM_OE_N=1.

Read beat:
- SRAM_OE_N=0, SRAM_DQ=Z.
- SRAM_DQ sampled into read_data[k*SRAM_DW +: SRAM_DW] at the end of beat k.

Bus idle:
- Outside ACCESS, SRAM_WE_N=1, SRAM_OE_N=1 and SRAM_DQ=Z.
- The DQ bus is never driven during a read.

Latency:
- Request seen in cycle 0 → ready=1 in cycle N+WAIT_CYCLES+1.
- Defaults: cycle 5.

read_data:
- Valid while ready is high in DONE.
- Held until the next read overwrites it; writes do not alter it.

Back-to-back requests:
- A request still high in the cycle after DONE is a new access; the pipeline must have advanced.

Optional Feature:
Macro SRAM_CTRL_ADDR_CHECK_EN.
- Defined:
  - Adds output addr_err (1 bit).
  - A request is invalid if address < BASE_ADDR, or address[log2(DATA_W/8)-1:0] ≠ 0, or word*N+N-1 ≥ 2^SRAM_AW.
  - An invalid request skips ACCESS/WAIT and goes IDLE → DONE, so ready appears in cycle 1.
  - No SRAM strobes are issued and read_data is unchanged.
  - addr_err=1 for exactly the DONE cycle; reset value 0.
- Undefined:
  - No addr_err port.
  - All addresses are accepted and wrap as above.

Decomposition:
- Package sram_ctrl_pkg:
  - state enum {IDLE, ACCESS, WAIT, DONE}.
  - Function clog2.
  - Derived constants BEATS = DATA_W/SRAM_DW and BYTE_SHIFT.
- Sub-module sram_dq_pad: tri-state driver, (oe, dout) → SRAM_DQ and din; instantiated once.

Test Plan:
- Write 0xDEADBEEF to address 1032 (defaults) → SRAM_ADDR 4 then 5, WE_N=0 in both beats, DQ=0xBEEF then 0xDEAD, ready=1 in cycle 5, DQ=Z afterwards.
- Read address 1032 with SRAM model preloaded 4:0xBEEF, 5:0xDEAD → OE_N=0 in both beats, DQ never driven by the DUT, read_data=0xDEADBEEF with ready in cycle 5.
- DATA_W=64, WAIT_CYCLES=0, write 0x0123456789ABCDEF to 1024 → addresses 0..3, data 0xCDEF, 0x89AB, 0x4567, 0x0123; ready in cycle 5; readback matches.
- wr_en=rd_en=1 at 1036 → executes a write only; rst=0 pulsed during beat 1 → WE_N=1, DQ=Z immediately, FSM in IDLE, read_data=0.
- SRAM_CTRL_ADDR_CHECK_EN defined: read 1000 and read 1026 → addr_err=1 and ready in cycle 1, no SRAM strobes; read 1028 → normal access, addr_err=0.
- Address 1024+4·2^17 with macro undefined → wraps to SRAM_ADDR 0 and 1.
